// File: rtl/ir_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_scheduler
// Purpose  : Shares one ir_encoder between NUM_REQ command sources. Sources
//            are arbitrated round-robin. The winner's address and command are
//            packed into the 32-bit frame word {~cmd, cmd, addr, addr}, which
//            is offered to the encoder through a valid/ready handshake. A
//            minimum spacing of FRAME_PERIOD_CYC clocks is enforced between
//            consecutive encoder handshakes.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            req_valid/ready  - per-requester handshake (req_ready is one-hot)
//            req_addr/req_cmd - packed 8-bit address/command per requester
//            enc_cmd/valid    - frame word and valid toward ir_encoder
//            enc_ready        - encoder idle/accept
//            busy             - high while a frame is in SEND or GAP
//            grant_id         - index of the last accepted requester
// Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_scheduler #(
    parameter  int NUM_REQ          = 2,
    parameter  int FRAME_PERIOD_CYC = 2700000,
    localparam int GNT_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            enc_cmd,
    output logic                   enc_valid,
    input  logic                   enc_ready,
    output logic                   busy,
    output logic [GNT_W-1:0]       grant_id
);

    localparam int               CNT_W    = $clog2(FRAME_PERIOD_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FRAME_PERIOD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [GNT_W-1:0]   ptr_q,       ptr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [31:0]        enc_cmd_q,   enc_cmd_d;
    logic               enc_valid_q, enc_valid_d;
    logic [GNT_W-1:0]   grant_q,     grant_d;

    logic               any_w;
    logic [GNT_W-1:0]   win_w;
    logic [7:0]         sel_addr_w;
    logic [7:0]         sel_cmd_w;
    int                 dist_w;
    int                 best_w;

    // Round-robin pick: the valid requester with the smallest forward
    // distance from the pointer (modulo NUM_REQ) wins.
    always_comb begin
        any_w  = 1'b0;
        win_w  = '0;
        dist_w = 0;
        best_w = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_w = i - int'(ptr_q);
            if (dist_w < 0) begin
                dist_w = dist_w + NUM_REQ;
            end
            if (req_valid[i] && (dist_w < best_w)) begin
                best_w = dist_w;
                win_w  = GNT_W'(i);
                any_w  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr_w = '0;
        sel_cmd_w  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_w == GNT_W'(i)) begin
                sel_addr_w = req_addr[8*i +: 8];
                sel_cmd_w  = req_cmd[8*i +: 8];
            end
        end
    end

    // Accept strobe is combinational so the requester sees it in the same
    // cycle it is selected; suppressed while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (!rst && (state_q == ST_IDLE) && any_w) begin
            req_ready = NUM_REQ'(1) << win_w;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        enc_cmd_d   = enc_cmd_q;
        enc_valid_d = enc_valid_q;
        grant_d     = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any_w) begin
                    enc_cmd_d   = {~sel_cmd_w, sel_cmd_w, sel_addr_w, sel_addr_w};
                    grant_d     = win_w;
                    ptr_d       = (int'(win_w) == NUM_REQ - 1) ? '0 : (win_w + GNT_W'(1));
                    enc_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (enc_ready) begin
                    enc_valid_d = 1'b0;
                    cnt_d       = CNT_W'(1);
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                // Counter saturates at the terminal value rather than wrapping.
                if (cnt_q == CNT_TERM) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                enc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            enc_cmd_q   <= '0;
            enc_valid_q <= 1'b0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            enc_cmd_q   <= enc_cmd_d;
            enc_valid_q <= enc_valid_d;
            grant_q     <= grant_d;
        end
    end

    assign enc_cmd   = enc_cmd_q;
    assign enc_valid = enc_valid_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_cmd_scheduler
// Purpose  : Directed self-checking bench for ir_cmd_scheduler with
//            NUM_REQ=2 and FRAME_PERIOD_CYC=20.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_cmd_scheduler;

    localparam int NR = 2;
    localparam int FP = 20;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_cmd   = '0;
    logic [1:0]  req_ready;
    logic [31:0] enc_cmd;
    logic        enc_valid;
    logic        enc_ready = 1'b1;
    logic        busy;
    logic [0:0]  grant_id;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    ir_cmd_scheduler #(
        .NUM_REQ          (NR),
        .FRAME_PERIOD_CYC (FP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_cmd   (req_cmd),
        .req_ready (req_ready),
        .enc_cmd   (enc_cmd),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b exp 00", req_ready); else pass_cnt++;
        total_cnt++; if (enc_valid !== 1'b0) $display("FAIL rst_enc_valid: got %b exp 0", enc_valid); else pass_cnt++;
        total_cnt++; if (enc_cmd !== 32'h0) $display("FAIL rst_enc_cmd: got %h exp 00000000", enc_cmd); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (grant_id !== 1'b0) $display("FAIL rst_grant: got %b exp 0", grant_id); else pass_cnt++;
        rst       = 1'b0;
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_single();
        int bad;
        req_addr[7:0] = 8'h07;
        req_cmd[7:0]  = 8'h04;
        req_valid     = 2'b01;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b exp 01", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        #1;
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL single_ready_pulse: got %b exp 00", req_ready); else pass_cnt++;
        total_cnt++; if (enc_valid !== 1'b1) $display("FAIL single_enc_valid: got %b exp 1", enc_valid); else pass_cnt++;
        total_cnt++; if (enc_cmd !== 32'hFB040707) $display("FAIL single_enc_cmd: got %h exp FB040707", enc_cmd); else pass_cnt++;
        total_cnt++; if (grant_id !== 1'b0) $display("FAIL single_grant: got %b exp 0", grant_id); else pass_cnt++;
        bad = 0;
        for (int k = 1; k < FP; k++) begin
            tick();
            if (busy !== 1'b1 || enc_valid !== 1'b0) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL single_gap_busy: got %0d bad cycles exp 0", bad); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int bad;
        bit to;
        // Pointer is 1 here; only requester 0 is valid, so it still wins.
        enc_ready      = 1'b0;
        req_addr[7:0]  = 8'h12;
        req_cmd[7:0]   = 8'h34;
        req_addr[15:8] = 8'h56;
        req_cmd[15:8]  = 8'h78;
        req_valid      = 2'b01;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL bp_ready: got %b exp 01", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b11;
        #1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            if (enc_valid !== 1'b1 || enc_cmd !== 32'hCB341212 || req_ready !== 2'b00) bad++;
            tick();
        end
        total_cnt++; if (bad !== 0) $display("FAIL bp_stable: got %0d bad cycles exp 0", bad); else pass_cnt++;
        enc_ready = 1'b1;
        #1;
        total_cnt++; if (enc_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b exp 1", enc_valid); else pass_cnt++;
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL bp_no_accept: got %b exp 00", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        #1;
        total_cnt++; if (enc_valid !== 1'b0) $display("FAIL bp_handshake: got %b exp 0", enc_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL bp_gap_busy: got %b exp 1", busy); else pass_cnt++;
        total_cnt++; if (grant_id !== 1'b0) $display("FAIL bp_grant: got %b exp 0", grant_id); else pass_cnt++;
        wait_idle(to);
        total_cnt++; if (to !== 1'b0) $display("FAIL bp_idle_timeout: got %b exp 0", to); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int  prev_hs;
        bit  to;
        logic [0:0]  exp_g;
        logic [31:0] exp_cmd;
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        req_addr[7:0]  = 8'hA0;
        req_cmd[7:0]   = 8'h11;
        req_addr[15:8] = 8'hA1;
        req_cmd[15:8]  = 8'h22;
        req_valid      = 2'b11;
        #1;
        prev_hs = 0;
        for (int f = 0; f < 4; f++) begin
            exp_g   = (f % 2 == 1) ? 1'b1 : 1'b0;
            exp_cmd = exp_g ? 32'hDD22A1A1 : 32'hEE11A0A0;
            to = 1'b1;
            for (int i = 0; i < 60; i++) begin
                if (req_ready !== 2'b00) begin
                    to = 1'b0;
                    break;
                end
                tick();
            end
            total_cnt++; if (to !== 1'b0) $display("FAIL rr_ready_timeout: frame %0d got timeout", f); else pass_cnt++;
            total_cnt++; if (req_ready !== (exp_g ? 2'b10 : 2'b01)) $display("FAIL rr_ready: frame %0d got %b exp %b", f, req_ready, (exp_g ? 2'b10 : 2'b01)); else pass_cnt++;
            tick();
            total_cnt++; if (grant_id !== exp_g) $display("FAIL rr_grant: frame %0d got %b exp %b", f, grant_id, exp_g); else pass_cnt++;
            total_cnt++; if (enc_valid !== 1'b1 || enc_cmd !== exp_cmd) $display("FAIL rr_frame: frame %0d got v=%b %h exp v=1 %h", f, enc_valid, enc_cmd, exp_cmd); else pass_cnt++;
            if (f > 0) begin
                total_cnt++; if ((cyc - prev_hs) !== FP + 1) $display("FAIL rr_spacing: frame %0d got %0d exp %0d", f, cyc - prev_hs, FP + 1); else pass_cnt++;
            end
            prev_hs = cyc;
            tick();
        end
        req_valid = 2'b00;
        #1;
        wait_idle(to);
        total_cnt++; if (to !== 1'b0) $display("FAIL rr_idle_timeout: got %b exp 0", to); else pass_cnt++;
    endtask

    task automatic test_frame_period();
        int t0;
        int bad;
        bit to;
        req_addr[7:0] = 8'h01;
        req_cmd[7:0]  = 8'h02;
        req_valid     = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        #1;
        total_cnt++; if (enc_valid !== 1'b1) $display("FAIL fp_first_valid: got %b exp 1", enc_valid); else pass_cnt++;
        t0 = cyc;
        for (int k = 0; k < 5; k++) tick();
        req_addr[15:8] = 8'h33;
        req_cmd[15:8]  = 8'h44;
        req_valid      = 2'b10;
        #1;
        bad = 0;
        while (cyc < t0 + FP) begin
            if (req_ready !== 2'b00) bad++;
            tick();
        end
        total_cnt++; if (bad !== 0) $display("FAIL fp_early_ready: got %0d bad cycles exp 0", bad); else pass_cnt++;
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL fp_ready_at_T20: got %b exp 10", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        #1;
        total_cnt++; if (enc_valid !== 1'b1 || enc_cmd !== 32'hBB443333) $display("FAIL fp_valid_at_T21: got v=%b %h exp v=1 BB443333", enc_valid, enc_cmd); else pass_cnt++;
        wait_idle(to);
        total_cnt++; if (to !== 1'b0) $display("FAIL fp_idle_timeout: got %b exp 0", to); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit to;
        // Reset while stalled in SEND
        enc_ready      = 1'b0;
        req_addr[15:8] = 8'h55;
        req_cmd[15:8]  = 8'h66;
        req_valid      = 2'b10;
        #1;
        tick();
        req_valid = 2'b00;
        #1;
        total_cnt++; if (enc_valid !== 1'b1 || grant_id !== 1'b1) $display("FAIL rm_send_setup: got v=%b g=%b exp v=1 g=1", enc_valid, grant_id); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        enc_ready = 1'b1;
        #1;
        total_cnt++; if (enc_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rm_send_rst: got v=%b busy=%b exp 0 0", enc_valid, busy); else pass_cnt++;
        total_cnt++; if (grant_id !== 1'b0 || enc_cmd !== 32'h0) $display("FAIL rm_send_rst_regs: got g=%b %h exp 0 00000000", grant_id, enc_cmd); else pass_cnt++;
        // Reset while in GAP
        req_valid = 2'b10;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        total_cnt++; if (busy !== 1'b1 || enc_valid !== 1'b0 || grant_id !== 1'b1) $display("FAIL rm_gap_setup: got busy=%b v=%b g=%b exp 1 0 1", busy, enc_valid, grant_id); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total_cnt++; if (enc_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rm_gap_rst: got v=%b busy=%b exp 0 0", enc_valid, busy); else pass_cnt++;
        total_cnt++; if (grant_id !== 1'b0 || enc_cmd !== 32'h0) $display("FAIL rm_gap_rst_regs: got g=%b %h exp 0 00000000", grant_id, enc_cmd); else pass_cnt++;
        req_valid = 2'b10;
        #1;
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL rm_post_ready: got %b exp 10", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        #1;
        total_cnt++; if (grant_id !== 1'b1 || enc_valid !== 1'b1 || enc_cmd !== 32'h99665555) $display("FAIL rm_post_frame: got g=%b v=%b %h exp 1 1 99665555", grant_id, enc_valid, enc_cmd); else pass_cnt++;
        wait_idle(to);
        total_cnt++; if (to !== 1'b0) $display("FAIL rm_idle_timeout: got %b exp 0", to); else pass_cnt++;
    endtask

    task automatic test_withdrawn();
        int bad;
        req_addr[7:0] = 8'h0A;
        req_cmd[7:0]  = 8'h0B;
        req_valid     = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        req_valid = 2'b10;
        #1;
        total_cnt++; if (req_ready !== 2'b00 || busy !== 1'b1) $display("FAIL wd_gap_ready: got r=%b busy=%b exp 00 1", req_ready, busy); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        #1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (enc_valid !== 1'b0 || req_ready !== 2'b00) bad++;
            tick();
        end
        total_cnt++; if (bad !== 0) $display("FAIL wd_no_frame: got %0d bad cycles exp 0", bad); else pass_cnt++;
        total_cnt++; if (grant_id !== 1'b0 || busy !== 1'b0) $display("FAIL wd_final: got g=%b busy=%b exp 0 0", grant_id, busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_frame_period();
        test_reset_mid();
        test_withdrawn();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_cmd_scheduler.md
Name: ir_cmd_scheduler

Overview:
Shares the single ir_encoder between NUM_REQ command sources, such as key scanners or a UART command path. Each source presents an 8-bit address and an 8-bit command. The block arbitrates between sources round-robin and assembles the 32-bit frame word for the encoder. It drives the encoder's valid/ready handshake and enforces a minimum frame-to-frame period. It sits between the requesters and ir_encoder; gpio/ir_output is unaffected.

Parameters:
NUM_REQ, 2, number of requesters (1..8).
FRAME_PERIOD_CYC, 2700000, minimum clk cycles between consecutive encoder handshakes (108 ms at 25 MHz); must be >= 2.
GNT_W, derived = max(1, clog2(NUM_REQ)), width of grant_id. This is a localparam, not overridable.

Ports:
clk  in  1  system clock (clk25 domain)
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request
req_addr  in  8*NUM_REQ  requester i address at [8i+7:8i]
req_cmd  in  8*NUM_REQ  requester i command at [8i+7:8i]
req_ready  out  NUM_REQ  one-hot accept; a transfer happens when req_valid[i] and req_ready[i] are both high
enc_cmd  out  32  frame word to ir_encoder.cmd
enc_valid  out  1  to ir_encoder.valid
enc_ready  in  1  from ir_encoder.ready (high = encoder idle)
busy  out  1  high in SEND or GAP
grant_id  out  GNT_W  index of the last accepted requester

Behaviour:
- Reset (rst high at a clk edge), applied on that edge:
  - state=IDLE; enc_valid=0; enc_cmd=0; grant_id=0.
  - RR pointer=0; gap counter=0; busy=0.
  - req_ready=0 while rst is high.
  - Reset mid-SEND or mid-GAP abandons the frame with no completion. ir_encoder shares the same rst.
- Frame format: enc_cmd = {~cmd, cmd, addr, addr}.
  - Bits [31:24] = ~cmd, [23:16] = cmd, [15:8] = addr, [7:0] = addr.
  - Example: addr=0x07, cmd=0x04 gives 0xFB040707.
- State IDLE:
  - Arbiter scans req_valid starting at the RR pointer, wrapping modulo NUM_REQ. The first set bit is the winner g.
  - req_ready is combinational: one-hot at bit g, only in IDLE and only when any req_valid is set. Otherwise it is all zeros.
  - On the accept cycle: latch addr/cmd of g into enc_cmd, grant_id<=g, RR pointer<=(g+1) mod NUM_REQ, next state SEND.
  - Exactly one accept per cycle at most.
- State SEND:
  - enc_valid=1 and enc_cmd is stable.
  - enc_valid never drops before the handshake (enc_valid & enc_ready at an edge).
  - On the handshake: enc_valid<=0, gap counter<=1, next state GAP.
  - Latency: enc_valid rises on the edge after req accept. If enc_ready is already high, the handshake occurs in that first SEND cycle.
- State GAP:
  - Counter increments every cycle.
  - When counter == FRAME_PERIOD_CYC-1, next state is IDLE.
  - As a result, the next accept is possible no earlier than cycle T+FRAME_PERIOD_CYC, where T is the handshake cycle. The next enc_valid then comes at T+FRAME_PERIOD_CYC+1.
  - Requests held during SEND/GAP are not accepted (req_ready=0) and are not lost if still held. The IDLE arbitration uses the RR pointer at that time.
- Requester dropping req_valid before accept: no effect, nothing recorded.
- Counter width: clog2(FRAME_PERIOD_CYC)+1 bits. The counter never wraps; it stops at the terminal value.
- NUM_REQ=1: pointer is always 0; the requester is granted whenever valid in IDLE.
- busy = (state != IDLE).
- grant_id holds its value until the next accept.

Test Plan:
All scenarios use FRAME_PERIOD_CYC=20 and NUM_REQ=2; the encoder model holds enc_ready high when idle.
1. Single request: req 0 with addr=0x07, cmd=0x04.
   - req_ready[0] pulses for one cycle.
   - Next cycle: enc_cmd=0xFB040707, enc_valid=1.
   - Handshake completes in one cycle; busy stays high for 20 cycles after the handshake.
2. Backpressure: hold enc_ready=0 for 15 cycles while in SEND.
   - enc_valid and enc_cmd stay stable for all 15 cycles.
   - Handshake occurs on the cycle enc_ready rises; no accept of other requests meanwhile.
3. Round-robin: both requesters continuously valid (req0 cmd=0x11, req1 cmd=0x22).
   - Grants alternate 0,1,0,1; enc_cmd[23:16] alternates 0x11,0x22.
   - Handshakes are spaced exactly 20 cycles apart plus encoder response time.
4. Frame period: a request arrives 5 cycles after a handshake.
   - No req_ready until T+20; enc_valid reasserts at T+21.
5. Reset mid-operation: rst for 1 cycle during SEND, then again during GAP.
   - Next edge: enc_valid=0, busy=0, grant_id=0, enc_cmd=0.
   - A subsequent request from req1 only is accepted immediately in IDLE.
6. Request withdrawn: req_valid[1] pulses for 1 cycle while the block is in GAP.
   - No accept and no frame is ever sent for it.
